// File: rtl/reg_file_pkg.sv
// Shared CPU datapath constants and the register-index type used by
// the decode, operand-mux and writeback stages.
package reg_file_pkg;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 3;
  localparam int NREG   = 2 ** AWIDTH;

  typedef logic [AWIDTH-1:0] reg_idx_t;
  typedef logic [DWIDTH-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_bypass_rd.sv
// Combinational read port with write-first bypass: a write in flight to
// the same index wins over the array contents.
module reg_bypass_rd
  import reg_file_pkg::*;
(
  input  reg_data_t regs_i [NREG],
  input  reg_idx_t  addr_i,
  input  logic      wr_en_i,
  input  reg_idx_t  wr_addr_i,
  input  reg_data_t wr_data_i,
  output reg_data_t data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
  end

endmodule : reg_bypass_rd

// File: rtl/reg_file.sv
// Decode-stage register file: 8x16 array, one writeback port, two bypassed
// read ports whose results are registered alongside the forwarded fields.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic [AWIDTH-1:0] rs_addr,
  input  logic [7:0]        offset_in,
  input  logic              sel_in,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_q,
  output logic [DWIDTH-1:0] rs_q,
  output logic [7:0]        offset,
  output logic              alu_in_sel,
  output logic              en_out
);

  reg_data_t regs_q [NREG];
  reg_data_t rd_d;
  reg_data_t rs_d;

  // Array write: index 0 is an ordinary register, nothing is hardwired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  reg_bypass_rd u_rd_port (
    .regs_i    (regs_q),
    .addr_i    (rd_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .data_o    (rd_d)
  );

  reg_bypass_rd u_rs_port (
    .regs_i    (regs_q),
    .addr_i    (rs_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .data_o    (rs_d)
  );

  // Operands and forwarded fields load together so they stay cycle-aligned;
  // they hold while the stage is idle, only en_out drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rs_q       <= '0;
      offset     <= '0;
      alu_in_sel <= 1'b0;
      en_out     <= 1'b0;
    end else begin
      en_out <= en_in;
      if (en_in) begin
        rd_q       <= rd_d;
        rs_q       <= rs_d;
        offset     <= offset_in;
        alu_in_sel <= sel_in;
      end
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic [2:0]  rd_addr;
  logic [2:0]  rs_addr;
  logic [7:0]  offset_in;
  logic        sel_in;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_q;
  logic [15:0] rs_q;
  logic [7:0]  offset;
  logic        alu_in_sel;
  logic        en_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_in      (en_in),
    .rd_addr    (rd_addr),
    .rs_addr    (rs_addr),
    .offset_in  (offset_in),
    .sel_in     (sel_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_q       (rd_q),
    .rs_q       (rs_q),
    .offset     (offset),
    .alu_in_sel (alu_in_sel),
    .en_out     (en_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_q"}, rd_q, 0);
    chk({tag, ".rs_q"}, rs_q, 0);
    chk({tag, ".offset"}, offset, 0);
    chk({tag, ".sel"}, alu_in_sel, 0);
    chk({tag, ".en_out"}, en_out, 0);
  endtask

  initial begin
    rst_n = 1'b0; en_in = 0; rd_addr = 0; rs_addr = 0; offset_in = 0;
    sel_in = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Write 0x1234 to r3
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    tick();
    // Read r3/r5 with forwarded fields
    wr_en = 0; en_in = 1; rd_addr = 3; rs_addr = 5; offset_in = 8'h80; sel_in = 1;
    tick();
    chk("wr_rd.rd_q", rd_q, 16'h1234);
    chk("wr_rd.rs_q", rs_q, 16'h0000);
    chk("wr_rd.en_out", en_out, 1);
    chk("fwd.offset", offset, 8'h80);
    chk("fwd.sel", alu_in_sel, 1);

    // Hold for 3 idle cycles while r3 is overwritten
    en_in = 0; offset_in = 8'h11; sel_in = 0; rd_addr = 0; rs_addr = 0;
    wr_en = 1; wr_addr = 3; wr_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.rd_q", rd_q, 16'h1234);
      chk("hold.en_out", en_out, 0);
      chk("hold.offset", offset, 8'h80);
      chk("hold.sel", alu_in_sel, 1);
    end

    // Same-cycle bypass on both ports
    wr_en = 1; wr_addr = 6; wr_data = 16'hBEEF;
    en_in = 1; rd_addr = 6; rs_addr = 6; offset_in = 8'h05; sel_in = 0;
    tick();
    chk("bypass.rd_q", rd_q, 16'hBEEF);
    chk("bypass.rs_q", rs_q, 16'hBEEF);
    chk("bypass.en_out", en_out, 1);
    chk("bypass.offset", offset, 8'h05);
    chk("bypass.sel", alu_in_sel, 0);

    // Array now holds both writes
    wr_en = 0; rd_addr = 3; rs_addr = 6;
    tick();
    chk("array.r3", rd_q, 16'hFFFF);
    chk("array.r6", rs_q, 16'hBEEF);

    // Fill r_i = 0x0100*i
    en_in = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 16'(i * 16'h0100);
      tick();
    end
    wr_en = 0;
    chk("fill.en_out", en_out, 0);

    // Full-rate reads r0..r7
    en_in = 1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); rs_addr = 3'(7 - i);
      tick();
      chk("tput.rd_q", rd_q, 32'(i * 16'h0100));
      chk("tput.rs_q", rs_q, 32'((7 - i) * 16'h0100));
      chk("tput.en_out", en_out, 1);
    end
    en_in = 0;
    tick();
    chk("tput.end_en_out", en_out, 0);
    chk("tput.end_rd_q", rd_q, 16'h0700);

    // Set forwarded fields nonzero, then asynchronous reset mid-cycle
    en_in = 1; offset_in = 8'h3C; sel_in = 1; rd_addr = 7; rs_addr = 6;
    tick();
    chk("pre_rst.rs_q", rs_q, 16'h0600);
    #2;
    rst_n = 0;
    wr_en = 1; wr_addr = 2; wr_data = 16'h5555;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk_all_zero("rst_hold");
    wr_en = 0; en_in = 0; rst_n = 1;

    // Every index reads back zero; r2 write during reset was dropped
    en_in = 1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); rs_addr = 3'(i);
      tick();
      chk("post_rst.rd_q", rd_q, 0);
      chk("post_rst.rs_q", rs_q, 0);
      chk("post_rst.en_out", en_out, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file
